// File: rtl/iobuf_turnaround_ctrl.sv
// rtl/iobuf_turnaround_ctrl.sv - half-duplex IOBUF bank sequencer with write/read turnaround
// Define IOBUF_CTRL_RD_SYNC_EN to pass pad_o through a 2-flop synchroniser before capture.
module iobuf_turnaround_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DRIVE_CYC  = 2,
  parameter int TURN_CYC   = 1,
  parameter int SAMPLE_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ack,
  output logic             busy,
  output logic [WIDTH-1:0] pad_i,
  output logic             pad_t,
  input  logic [WIDTH-1:0] pad_o
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN, S_SAMPLE} state_e;

  logic [WIDTH-1:0] rd_src;

`ifdef IOBUF_CTRL_RD_SYNC_EN
  localparam int SAMPLE_LEN = SAMPLE_CYC + 2;
  // SAMPLE_CYC+2 can reach 17 cycles, one more than a 4-bit count holds
  localparam int CNT_W      = 5;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_o;
      sync2_q <= sync1_q;
    end
  end

  assign rd_src = sync2_q;
`else
  localparam int SAMPLE_LEN = SAMPLE_CYC;
  localparam int CNT_W      = 4;

  assign rd_src = pad_o;
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_rd_q;
  logic             pad_t_q;
  logic [WIDTH-1:0] pad_i_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ack_q;
  logic             rd_ack_q;
  logic             busy_q;

  logic             take_wr_d;
  logic             take_rd_d;

  // The cycle carrying rd_ack is skipped so a held rd_req is not re-served.
  always_comb begin
    take_wr_d = 1'b0;
    take_rd_d = 1'b0;
    if (state_q == S_IDLE && !rd_ack_q) begin
      if (wr_req && rd_req) begin
        take_wr_d = last_rd_q;
        take_rd_d = !last_rd_q;
      end else begin
        take_wr_d = wr_req;
        take_rd_d = rd_req;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b1;
      pad_t_q   <= 1'b1;
      pad_i_q   <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (take_wr_d) begin
            state_q   <= S_DRIVE;
            cnt_q     <= CNT_W'(DRIVE_CYC - 1);
            pad_i_q   <= wr_data;
            pad_t_q   <= 1'b0;
            wr_ack_q  <= (DRIVE_CYC == 1);
            busy_q    <= 1'b1;
            last_rd_q <= 1'b0;
          end else if (take_rd_d) begin
            state_q   <= S_SAMPLE;
            cnt_q     <= CNT_W'(SAMPLE_LEN - 1);
            busy_q    <= 1'b1;
            last_rd_q <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == '0) begin
            pad_t_q <= 1'b1;
            if (TURN_CYC == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_TURN;
              cnt_q   <= CNT_W'(TURN_CYC - 1);
            end
          end else begin
            cnt_q    <= cnt_q - 1'b1;
            wr_ack_q <= (cnt_q == CNT_W'(1));
          end
        end
        S_TURN: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == '0) begin
            rd_data_q <= rd_src;
            rd_ack_q  <= 1'b1;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          pad_t_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ack  = wr_ack_q;
  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign pad_i   = pad_i_q;
  assign pad_t   = pad_t_q;

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// tb/tb_iobuf_turnaround_ctrl.sv - scoreboard bench for iobuf_turnaround_ctrl
// Three instances share the clock: TURN_CYC of 1 (default), 3 and 0.
module tb_iobuf_turnaround_ctrl;

  localparam int D = 2;
  localparam int S = 2;
`ifdef IOBUF_CTRL_RD_SYNC_EN
  localparam int RL = S + 3;
`else
  localparam int RL = S + 1;
`endif

  typedef struct {
    logic       is_rd;
    logic [7:0] data;
    int         cyc;
  } sb_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_req  [3];
  logic [7:0] wr_data [3];
  logic       wr_ack  [3];
  logic       rd_req  [3];
  logic [7:0] rd_data [3];
  logic       rd_ack  [3];
  logic       busy    [3];
  logic [7:0] pad_i   [3];
  logic       pad_t   [3];
  logic [7:0] pad_o   [3];
  logic       rd_inflight [3];

  sb_t sbq [3][$];
  sb_t mon_e;
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iobuf_turnaround_ctrl #(
      .WIDTH(8), .DRIVE_CYC(D), .TURN_CYC((g == 0) ? 1 : (g == 1) ? 3 : 0), .SAMPLE_CYC(S)
    ) u_dut (
      .CLK(CLK), .RST(RST),
      .wr_req(wr_req[g]), .wr_data(wr_data[g]), .wr_ack(wr_ack[g]),
      .rd_req(rd_req[g]), .rd_data(rd_data[g]), .rd_ack(rd_ack[g]),
      .busy(busy[g]), .pad_i(pad_i[g]), .pad_t(pad_t[g]), .pad_o(pad_o[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion scoreboard plus the no-drive-during-read invariant.
  always @(negedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < 3; k++) begin
        if (rd_inflight[k]) check_eq("rd_no_drive", pad_t[k], 1'b1);
        if (wr_ack[k] || rd_ack[k]) begin
          if (sbq[k].size() == 0) begin
            check_eq("unexp_ack", {wr_ack[k], rd_ack[k]}, 2'b00);
          end else begin
            mon_e = sbq[k].pop_front();
            check_eq("ack_kind", {wr_ack[k], rd_ack[k]}, mon_e.is_rd ? 2'b01 : 2'b10);
            check_eq("ack_cyc", cyc, mon_e.cyc);
            check_eq("ack_data", mon_e.is_rd ? rd_data[k] : pad_i[k], mon_e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic is_rd, input logic [7:0] d, input int c);
    sb_t e;
    e.is_rd = is_rd;
    e.data  = d;
    e.cyc   = c;
    sbq[k].push_back(e);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((busy[k] || rd_ack[k]) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check_eq("idle_timeout", busy[k], 1'b0);
  endtask

  task automatic write_txn(input int k, input logic [7:0] d, input int turn);
    int c;
    wait_idle(k);
    wr_data[k] = d;
    wr_req[k]  = 1'b1;
    c = cyc;
    push_exp(k, 1'b0, d, c + D);
    for (int i = 1; i <= D; i++) begin
      @(negedge CLK);
      check_eq("drv_t", pad_t[k], 1'b0);
      check_eq("drv_i", pad_i[k], d);
      check_eq("drv_ack", wr_ack[k], (i == D));
      wr_data[k] = ~d;
    end
    wr_req[k] = 1'b0;
    for (int i = 1; i <= turn; i++) begin
      @(negedge CLK);
      check_eq("turn_t", pad_t[k], 1'b1);
      check_eq("turn_busy", busy[k], 1'b1);
    end
    @(negedge CLK);
    check_eq("wr_idle_busy", busy[k], 1'b0);
    check_eq("wr_idle_t", pad_t[k], 1'b1);
  endtask

  task automatic read_txn(input int k, input logic [7:0] d);
    int c;
    wait_idle(k);
    pad_o[k]  = d;
    rd_req[k] = 1'b1;
    rd_inflight[k] = 1'b1;
    c = cyc;
    push_exp(k, 1'b1, d, c + RL);
    for (int i = 1; i < RL; i++) begin
      @(negedge CLK);
      check_eq("smp_ack", rd_ack[k], 1'b0);
      check_eq("smp_busy", busy[k], 1'b1);
    end
    @(negedge CLK);
    check_eq("rd_ack", rd_ack[k], 1'b1);
    check_eq("rd_data", rd_data[k], d);
    check_eq("rd_idle_busy", busy[k], 1'b0);
    rd_req[k] = 1'b0;
    rd_inflight[k] = 1'b0;
  endtask

  task automatic check_reset_vals(input int k);
    check_eq("rst_pad_t", pad_t[k], 1'b1);
    check_eq("rst_pad_i", pad_i[k], 8'h00);
    check_eq("rst_rd_data", rd_data[k], 8'h00);
    check_eq("rst_wr_ack", wr_ack[k], 1'b0);
    check_eq("rst_rd_ack", rd_ack[k], 1'b0);
    check_eq("rst_busy", busy[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    for (int k = 0; k < 3; k++) begin
      wr_req[k] = 1'b0; wr_data[k] = 8'h00; rd_req[k] = 1'b0;
      pad_o[k] = 8'h00; rd_inflight[k] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) check_reset_vals(k);

    write_txn(0, 8'hA5, 1);
    read_txn(0, 8'h3C);

    // Both requesters held: write, read, write, read.
    wait_idle(0);
    wr_data[0] = 8'h11;
    pad_o[0]   = 8'h22;
    wr_req[0]  = 1'b1;
    rd_req[0]  = 1'b1;
    c = cyc;
    push_exp(0, 1'b0, 8'h11, c + D);
    c = c + D + 1 + 1;
    push_exp(0, 1'b1, 8'h22, c + RL);
    c = c + RL + 1;
    push_exp(0, 1'b0, 8'h11, c + D);
    c = c + D + 1 + 1;
    push_exp(0, 1'b1, 8'h22, c + RL);
    n = 0;
    while (sbq[0].size() != 0 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check_eq("both_done", sbq[0].size(), 0);
    wr_req[0] = 1'b0;
    rd_req[0] = 1'b0;

    write_txn(1, 8'h5A, 3);
    read_txn(1, 8'hC6);

    write_txn(2, 8'h81, 0);
    write_txn(2, 8'h7E, 0);
    read_txn(2, 8'hE7);

    // Reset in the middle of a drive burst.
    wait_idle(0);
    wr_data[0] = 8'hC3;
    wr_req[0]  = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("t1_drv_t", pad_t[0], 1'b0);
    #1;
    RST = 1'b1;
    #1;
    check_reset_vals(0);
    wr_req[0] = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_reset_vals(0);
    read_txn(0, 8'h5A);
    write_txn(0, 8'h96, 1);

    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) check_eq("sb_left", sbq[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
